// File: rtl/spw_tx_arbiter.sv
// Packet-level round-robin arbiter merging NREQ 9-bit packet streams into the SpaceWire transmit FIFO.
// Define SPW_TX_TIMEOUT_EN to build the stall timeout that aborts a stuck packet with an EEP.
module spw_tx_arbiter #(
    parameter int         NREQ        = 4,
    parameter logic [2:0] RUN_STATE   = 3'd5,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic              CLOCK,
    input  logic              RESETn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [9*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2:0]        link_state,
    input  logic              tx_full,
    output logic [8:0]        tx_data,
    output logic              tx_wr,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [15:0]       pkt_count
);

    localparam int IDXW = (NREQ > 2) ? $clog2(NREQ) : 1;

`ifdef SPW_TX_TIMEOUT_EN
    localparam int         SCW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [8:0] EEP_BEAT = 9'h101;
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, ABORT} state_t;
    logic [SCW-1:0] stall_cnt;
`else
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
`endif

    state_t          state;
    logic [IDXW-1:0] g_idx;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] rr_next;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            link_run;
    logic            accept;
    logic [8:0]      beat;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("spw_tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYC positive");
    end

    // Returns {found, index} of the first valid requester at or after ptr, wrapping at NREQ-1.
    function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] vld,
                                              input logic [IDXW-1:0] ptr);
        logic [IDXW:0] res;
        int            idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (vld[IDXW'(idx)]) res = {1'b1, IDXW'(idx)};
        end
        return res;
    endfunction

    assign link_run              = (link_state == RUN_STATE);
    assign beat                  = req_data[9*int'(g_idx) +: 9];
    assign rr_next               = (g_idx == IDXW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
    assign {pick_any, pick_idx}  = rr_pick(req_valid, rr_ptr);
    assign accept                = |req_ready;

    // The !tx_wr term spaces writes two cycles apart so tx_full has settled before the next one.
    always_comb begin
        req_ready = '0;
        case (state)
            XFER:    req_ready[g_idx] = req_valid[g_idx] & ~tx_full & ~tx_wr & link_run;
            DRAIN:   req_ready[g_idx] = req_valid[g_idx];
            default: req_ready = '0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            g_idx     <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            tx_data   <= '0;
            tx_wr     <= 1'b0;
            pkt_count <= '0;
`ifdef SPW_TX_TIMEOUT_EN
            stall_cnt <= '0;
`endif
        end else begin
            tx_wr <= 1'b0;
            case (state)
                IDLE: begin
`ifdef SPW_TX_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                    if (link_run && pick_any) begin
                        g_idx <= pick_idx;
                        grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy  <= 1'b1;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (!link_run) begin
                        // The CODEC flushes its FIFO on link loss, so no EEP is written here.
                        state <= DRAIN;
                    end else if (accept) begin
                        tx_data <= beat;
                        tx_wr   <= 1'b1;
                        if (beat[8]) begin
                            pkt_count <= pkt_count + 16'd1;
                            rr_ptr    <= rr_next;
                            grant     <= '0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
`ifdef SPW_TX_TIMEOUT_EN
                        stall_cnt <= '0;
                    end else if (!req_valid[g_idx]) begin
                        if (stall_cnt == SCW'(TIMEOUT_CYC - 1)) begin
                            stall_cnt <= '0;
                            state     <= ABORT;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
`endif
                    end
                end
                DRAIN: begin
                    if (accept && beat[8]) begin
                        rr_ptr <= rr_next;
                        grant  <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
`ifdef SPW_TX_TIMEOUT_EN
                ABORT: begin
                    // Terminate the stalled packet in the FIFO, then swallow the rest of it.
                    if (!tx_full && !tx_wr) begin
                        tx_data   <= EEP_BEAT;
                        tx_wr     <= 1'b1;
                        pkt_count <= pkt_count + 16'd1;
                        state     <= DRAIN;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spw_tx_arbiter.sv
// Randomized scoreboard bench for spw_tx_arbiter: packets are queued per requester and the expected
// FIFO write order is derived from round-robin service order over the requesters that have a packet.
module tb_spw_tx_arbiter;
    localparam int         NREQ = 4;
    localparam logic [2:0] RUN  = 3'd5;

    logic              CLOCK;
    logic              RESETn;
    logic [NREQ-1:0]   req_valid;
    logic [9*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [2:0]        link_state;
    logic              tx_full;
    logic [8:0]        tx_data;
    logic              tx_wr;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [15:0]       pkt_count;

    spw_tx_arbiter #(.NREQ(NREQ), .RUN_STATE(RUN), .TIMEOUT_CYC(1024)) dut (
        .CLOCK(CLOCK), .RESETn(RESETn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .link_state(link_state), .tx_full(tx_full),
        .tx_data(tx_data), .tx_wr(tx_wr), .grant(grant), .busy(busy), .pkt_count(pkt_count)
    );

    logic [8:0] src_q[NREQ][$];
    logic [8:0] tmp_pkt[NREQ][$];
    logic [8:0] exp_q[$];
    bit         started[NREQ];
    int         acc_cnt[NREQ];
    int         wr_cyc[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         steady = 1'b1;
    bit         full_rand = 1'b0;
    int         m_rr = 0;
    int         m_count = 0;

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    // Monitor: every FIFO write must be the next expected beat and obey the write spacing rules.
    initial begin
        logic [8:0] e;
        bit prev_wr, prev_full;
        prev_wr = 1'b0;
        prev_full = 1'b0;
        forever begin
            @(negedge CLOCK);
            cyc++;
            if (RESETn) begin
                if (tx_wr) begin
                    wr_cyc.push_back(cyc);
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL tx_write: got unexpected write tx_data=%h, expected no write", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_data !== e) begin
                            n_fail++;
                            $display("FAIL tx_data: got %h, expected %h", tx_data, e);
                        end
                    end
                    n_cmp++;
                    if (prev_wr || prev_full) begin
                        n_fail++;
                        $display("FAIL tx_spacing: got write with prev_wr=%0b prev_full=%0b, expected both 0",
                                 prev_wr, prev_full);
                    end
                end
                n_cmp++;
                if (!$onehot0(grant) || !$onehot0(req_ready) || ((req_ready & ~grant) != '0)) begin
                    n_fail++;
                    $display("FAIL ready_grant: got req_ready=%b grant=%b, expected ready within one-hot grant",
                             req_ready, grant);
                end
            end
            prev_wr = tx_wr;
            prev_full = tx_full;
        end
    end

    task automatic drive();
        logic [NREQ-1:0]   v;
        logic [9*NREQ-1:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                v[i] = (!started[i] || steady) ? 1'b1 : ($urandom_range(0, 3) != 0);
                d[9*i +: 9] = src_q[i][0];
            end
        end
        req_valid = v;
        req_data = d;
    endtask

    task automatic tick();
        logic [NREQ-1:0] acc;
        @(negedge CLOCK);
        acc = req_valid & req_ready;
        @(posedge CLOCK);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && src_q[i].size() > 0) begin
                started[i] = !src_q[i][0][8];
                void'(src_q[i].pop_front());
                acc_cnt[i]++;
            end
        end
        if (full_rand) tx_full = ($urandom_range(0, 4) == 0);
        drive();
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NREQ; i++)
            if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            tick();
            n++;
            done = !busy && exp_q.size() == 0 && src_empty();
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: got busy=%0b exp_left=%0d, expected idle with all beats written",
                     name, busy, exp_q.size());
        end
    endtask

    task automatic make_pkt(input int i, input int ndata);
        tmp_pkt[i].delete();
        for (int k = 0; k < ndata; k++) tmp_pkt[i].push_back({1'b0, 8'($urandom)});
        tmp_pkt[i].push_back({1'b1, 7'd0, 1'($urandom)});
    endtask

    // Requesters in the subset are served whole, in round-robin order starting at the model pointer.
    task automatic commit(input logic [NREQ-1:0] subset);
        int idx, last;
        last = m_rr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (subset[idx]) begin
                foreach (tmp_pkt[idx][j]) exp_q.push_back(tmp_pkt[idx][j]);
                m_count++;
                last = idx;
            end
        end
        m_rr = (last + 1) % NREQ;
        for (int i = 0; i < NREQ; i++)
            if (subset[i]) foreach (tmp_pkt[i][j]) src_q[i].push_back(tmp_pkt[i][j]);
        drive();
    endtask

    task automatic wait_acc(input int i, input int target, input string name);
        int n;
        n = 0;
        while (acc_cnt[i] < target && n < 200) begin
            tick();
            n++;
        end
        check({name, "_acc"}, acc_cnt[i], target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_tx_wr"}, tx_wr, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pkt_count"}, pkt_count, 0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    initial begin
        int base;
        logic [NREQ-1:0] sub;
        RESETn = 1'b0;
        req_valid = '0;
        req_data = '0;
        link_state = RUN;
        tx_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            started[i] = 1'b0;
            acc_cnt[i] = 0;
        end
        repeat (3) tick();
        check_reset_outputs("rst_hold");
        RESETn = 1'b1;
        tick();
        check_reset_outputs("rst_release");

        // Single packet, steady source: writes every second cycle.
        wr_cyc.delete();
        make_pkt(0, 3);
        commit(4'b0001);
        wait_done("t1");
        check("t1_writes", wr_cyc.size(), 4);
        for (int k = 1; k < wr_cyc.size(); k++) check("t1_write_gap", wr_cyc[k] - wr_cyc[k-1], 2);
        check("t1_pkt_count", pkt_count, m_count);

        // Two requesters together: packets back to back, never interleaved.
        make_pkt(1, 4);
        make_pkt(3, 2);
        commit(4'b1010);
        wait_done("t2");
        check("t2_pkt_count", pkt_count, m_count);

        // FIFO full mid-packet: nothing consumed or written until it clears.
        base = acc_cnt[0];
        make_pkt(0, 4);
        commit(4'b0001);
        wait_acc(0, base + 2, "t3");
        tx_full = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t3_ready_while_full", req_ready, 0);
            check("t3_wr_while_full", tx_wr, 0);
        end
        check("t3_acc_while_full", acc_cnt[0], base + 2);
        tx_full = 1'b0;
        wait_done("t3");
        check("t3_pkt_count", pkt_count, m_count);

        // Link leaves Run after two beats: remainder discarded, packet not counted.
        base = acc_cnt[2];
        make_pkt(2, 6);
        exp_q.push_back(tmp_pkt[2][0]);
        exp_q.push_back(tmp_pkt[2][1]);
        foreach (tmp_pkt[2][j]) src_q[2].push_back(tmp_pkt[2][j]);
        m_rr = 3;
        drive();
        wait_acc(2, base + 2, "t4");
        link_state = 3'd2;
        wait_done("t4");
        check("t4_pkt_count", pkt_count, m_count);
        link_state = RUN;
        tick();

        // Randomized rounds with dropping sources and a flickering full flag.
        steady = 1'b0;
        full_rand = 1'b1;
        for (int r = 0; r < 30; r++) begin
            sub = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) if (sub[i]) make_pkt(i, $urandom_range(0, 5));
            commit(sub);
            wait_done("rnd");
            check("rnd_pkt_count", pkt_count, m_count);
        end
        steady = 1'b1;
        full_rand = 1'b0;
        tx_full = 1'b0;
        tick();

        // Reset mid-packet: outputs clear at once and arbitration restarts from requester 0.
        make_pkt(1, 1);
        commit(4'b0010);
        wait_done("pre_rst");
        base = acc_cnt[3];
        make_pkt(3, 5);
        commit(4'b1000);
        wait_acc(3, base + 2, "mid_rst");
        #1;
        RESETn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete();
            started[i] = 1'b0;
        end
        exp_q.delete();
        drive();
        repeat (2) tick();
        RESETn = 1'b1;
        m_rr = 0;
        m_count = 0;
        tick();
        make_pkt(0, 2);
        make_pkt(2, 3);
        commit(4'b0101);
        wait_done("post_rst");
        check("post_rst_pkt_count", pkt_count, m_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
